// File: rtl/pm_writer.sv
// pm_writer: streams little-endian byte pairs into program memory as 16-bit words and verifies each by readback.
//   clk_i, rst_ni                       clock, async active-low reset
//   start_i, base_i, len_i              start request with first word address and word count
//   abort_i                             abandon the running operation
//   byte_i, byte_valid_i, byte_ready_o  byte stream handshake
//   pm_addr_o, pm_data_o, pm_we_o       PM write port
//   pm_data_i                           PM read data (1-cycle registered read)
//   busy_o, done_o, err_o               status: running, completion pulse, sticky verify error
module pm_writer #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 13
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [ADDR_W-1:0]    base_i,
  input  logic [ADDR_W:0]      len_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic [ADDR_W-1:0]    pm_addr_o,
  output logic [WORD_SIZE-1:0] pm_data_o,
  output logic                 pm_we_o,
  input  logic [WORD_SIZE-1:0] pm_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);
  typedef enum logic [2:0] {IDLE, FILL_LO, FILL_HI, WRITE, VERIFY, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d, pm_addr_q, pm_addr_d;
  logic [ADDR_W:0]       rem_q, rem_d;
  logic [7:0]            lo_q, lo_d;
  logic [WORD_SIZE-1:0]  pm_data_q, pm_data_d;
  logic                  err_q, err_d;
  logic                  xfer, mismatch;
  assign byte_ready_o = state_q == FILL_LO || state_q == FILL_HI;
  assign busy_o       = byte_ready_o || state_q == WRITE || state_q == VERIFY;
  assign pm_we_o      = state_q == WRITE;
  assign done_o       = state_q == DONE;
  assign pm_addr_o    = pm_addr_q;
  assign pm_data_o    = pm_data_q;
  assign xfer         = byte_valid_i && byte_ready_o;
  assign mismatch     = state_q == VERIFY && pm_data_i != pm_data_q;
  // the mismatch is reported already in the VERIFY cycle, then held by err_q
  assign err_o        = err_q || (mismatch && !abort_i);
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    lo_d      = lo_q;
    pm_addr_d = pm_addr_q;
    pm_data_d = pm_data_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        addr_d  = base_i;
        rem_d   = len_i;
        err_d   = 1'b0;
        state_d = len_i == '0 ? DONE : FILL_LO;
      end
      FILL_LO: if (xfer) begin
        lo_d    = byte_i;
        state_d = FILL_HI;
      end
      // output registers load only here so they hold steady while the next word fills
      FILL_HI: if (xfer) begin
        pm_data_d = WORD_SIZE'({byte_i, lo_q});
        pm_addr_d = addr_q;
        state_d   = WRITE;
      end
      WRITE: state_d = VERIFY;
      VERIFY: if (mismatch) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        rem_d   = rem_q - (ADDR_W+1)'(1);
        state_d = rem_q == (ADDR_W+1)'(1) ? DONE : FILL_LO;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && busy_o) begin
      state_d = IDLE;
      err_d   = err_q;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      lo_q      <= '0;
      pm_addr_q <= '0;
      pm_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      lo_q      <= lo_d;
      pm_addr_q <= pm_addr_d;
      pm_data_q <= pm_data_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_pm_writer.sv
// tb_pm_writer: directed self-checking bench for pm_writer with a PM model and a byte-queue source.
module tb_pm_writer;
  logic        clk_i = 0, rst_ni = 0, start_i = 0, abort_i = 0;
  logic [12:0] base_i = 0;
  logic [13:0] len_i = 0;
  logic [7:0]  byte_i = 0;
  logic        byte_valid_i = 0, byte_ready_o;
  logic [12:0] pm_addr_o;
  logic [15:0] pm_data_o, pm_data_i = 0;
  logic        pm_we_o, busy_o, done_o, err_o;
  pm_writer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .base_i(base_i), .len_i(len_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .pm_addr_o(pm_addr_o), .pm_data_o(pm_data_o),
    .pm_we_o(pm_we_o), .pm_data_i(pm_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  int n_cmp = 0, n_err = 0;
  int cyc = 0, nw = 0, nd = 0, npop = 0;
  logic [12:0] wa [64];
  logic [15:0] wd [64];
  int          wc [64];
  logic [15:0] mem [8192];
  logic        bad5 = 0, stall_en = 0;
  logic [7:0]  bq [$];
  always @(posedge clk_i) cyc <= cyc + 1;
  // PM model: write on the edge, registered read; address 5 can be forced to read 0xFFFF
  always @(posedge clk_i) begin
    if (pm_we_o) mem[pm_addr_o] <= pm_data_o;
    pm_data_i <= (bad5 && pm_addr_o == 13'h5) ? 16'hFFFF : pm_we_o ? pm_data_o : mem[pm_addr_o];
  end
  always @(negedge clk_i) begin
    if (pm_we_o && nw < 64) begin
      wa[nw] = pm_addr_o;
      wd[nw] = pm_data_o;
      wc[nw] = cyc;
      nw++;
    end
    if (done_o) nd++;
  end
  initial begin
    logic x;
    forever begin
      @(negedge clk_i);
      x = byte_valid_i && byte_ready_o;
      @(posedge clk_i);
      if (x && bq.size() > 0) begin
        void'(bq.pop_front());
        npop++;
      end
      #1;
      byte_valid_i = bq.size() > 0 && (!stall_en || $urandom_range(0, 1) == 1);
      byte_i = bq.size() > 0 ? bq[0] : 8'h00;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic start(input logic [12:0] b, input logic [13:0] l);
    start_i = 1; base_i = b; len_i = l;
    tick();
    start_i = 0;
  endtask
  task automatic wait_done();
    for (int k = 0; k < 300 && !done_o; k++) tick();
    check("done_seen", {31'b0, done_o}, 1);
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {pm_we_o, busy_o, done_o, err_o, byte_ready_o}, 0);
    check({tag, "_addr"}, {19'b0, pm_addr_o}, 0);
    check({tag, "_data"}, {16'b0, pm_data_o}, 0);
  endtask
  initial begin
    int w0, d0, c0, p0;
    #2;
    check_all_zero("reset");
    tick(); tick();
    rst_ni = 1;
    tick();
    check_all_zero("post_reset");
    // two words back-to-back
    bq = '{8'h34, 8'h12, 8'h78, 8'h56};
    tick();
    w0 = nw; d0 = nd; c0 = cyc;
    start(13'h0100, 14'd2);
    check("t1_busy_ready", {busy_o, byte_ready_o}, 2'b11);
    wait_done();
    check("t1_nw", nw - w0, 2);
    check("t1_w0", {wa[w0], wd[w0]}, {13'h0100, 16'h1234});
    check("t1_w1", {wa[w0+1], wd[w0+1]}, {13'h0101, 16'h5678});
    check("t1_latency", wc[w0] - c0, 3);
    check("t1_spacing", wc[w0+1] - wc[w0], 4);
    check("t1_err_busy", {err_o, busy_o}, 0);
    tick();
    check("t1_nd", nd - d0, 1);
    check("t1_idle", {busy_o, done_o, byte_ready_o}, 0);
    check("t1_hold", {pm_addr_o, pm_data_o}, {13'h0101, 16'h5678});
    // zero length
    w0 = nw;
    bq = '{8'hEE};
    tick();
    start(13'h0300, 14'd0);
    check("t2_done_ready_busy", {done_o, byte_ready_o, busy_o}, 3'b100);
    tick();
    check("t2_after", {done_o, byte_ready_o, busy_o}, 0);
    check("t2_nw", nw - w0, 0);
    check("t2_byte_kept", bq.size(), 1);
    bq.delete();
    // verify mismatch at address 5
    bad5 = 1;
    w0 = nw; d0 = nd;
    bq = '{8'h01, 8'hAA, 8'h02, 8'hBB, 8'h03, 8'hCC};
    tick();
    start(13'h0004, 14'd3);
    for (int k = 0; k < 100 && !(nw - w0 == 2 && !pm_we_o); k++) tick();
    check("t3_err_in_verify", {pm_we_o, busy_o, err_o, pm_addr_o}, {1'b0, 1'b1, 1'b1, 13'h0005});
    wait_done();
    check("t3_err_done", err_o, 1);
    check("t3_nw", nw - w0, 2);
    check("t3_w0", {wa[w0], wd[w0]}, {13'h0004, 16'hAA01});
    check("t3_w1", {wa[w0+1], wd[w0+1]}, {13'h0005, 16'hBB02});
    tick();
    check("t3_nd", nd - d0, 1);
    check("t3_err_sticky", err_o, 1);
    bad5 = 0;
    bq.delete();
    // address wrap
    w0 = nw;
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    tick();
    start(13'h1FFF, 14'd2);
    check("t4_err_cleared", err_o, 0);
    wait_done();
    check("t4_nw", nw - w0, 2);
    check("t4_w0", {wa[w0], wd[w0]}, {13'h1FFF, 16'h2211});
    check("t4_w1", {wa[w0+1], wd[w0+1]}, {13'h0000, 16'h4433});
    check("t4_err", err_o, 0);
    tick();
    // abort in FILL_HI with stalled bytes
    stall_en = 1;
    w0 = nw; d0 = nd; p0 = npop;
    bq = '{8'h55, 8'h66, 8'h77, 8'h88};
    tick();
    start(13'h0010, 14'd4);
    for (int k = 0; k < 200 && npop == p0; k++) @(negedge clk_i);
    check("t5_in_fill_hi", {busy_o, byte_ready_o, npop - p0}, {1'b1, 1'b1, 32'd1});
    abort_i = 1;
    tick();
    abort_i = 0;
    check("t5_idle", {busy_o, byte_ready_o, done_o}, 0);
    for (int k = 0; k < 10; k++) tick();
    check("t5_no_write", nw - w0, 0);
    check("t5_no_done", nd - d0, 0);
    bq.delete();
    // start while busy is ignored
    w0 = nw; d0 = nd;
    bq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    tick();
    start(13'h0020, 14'd2);
    start(13'h0030, 14'd1);
    wait_done();
    check("t5b_nw", nw - w0, 2);
    check("t5b_w0", {wa[w0], wd[w0]}, {13'h0020, 16'hB2A1});
    check("t5b_w1", {wa[w0+1], wd[w0+1]}, {13'h0021, 16'hD4C3});
    tick();
    check("t5b_nd", nd - d0, 1);
    stall_en = 0;
    bq.delete();
    // async reset during WRITE
    w0 = nw; d0 = nd;
    bq = '{8'h99, 8'h77};
    tick();
    start(13'h0040, 14'd1);
    tick(); tick();
    check("t6_in_write", {pm_we_o, pm_addr_o, pm_data_o}, {1'b1, 13'h0040, 16'h7799});
    rst_ni = 0;
    #1;
    check_all_zero("t6_reset");
    tick(); tick();
    check("t6_no_log", {nw - w0, nd - d0}, 0);
    rst_ni = 1;
    tick(); tick();
    check_all_zero("t6_after");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pm_writer.md
Name: pm_writer

Overview:
- Sequencer that drives the write port of the CPU-writable program memory (the SPM-style RAM) from a byte stream, e.g. a bootloader UART receiver.
- Assembles little-endian byte pairs into 16-bit words and writes them to consecutive PM addresses starting at a base.
- Reads back every word through the PM read port and flags the first mismatch.
- Sits between the byte source and the PM port mux: pm_addr_o/pm_data_o/pm_we_o feed addr_i/data_i/we_i; pm_data_i comes from data_o.

Parameters:
- WORD_SIZE, 16, PM word width; fixed at 16 (two bytes per word).
- ADDR_W, 13, PM address width in words.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_ni  in  1  asynchronous reset, active low
- start_i  in  1  one-cycle start request, honoured only in IDLE
- abort_i  in  1  synchronous abort, honoured in any non-IDLE state
- base_i  in  ADDR_W  first word address, sampled on accepted start
- len_i  in  ADDR_W+1  number of words to write, sampled on accepted start
- byte_i  in  8  incoming byte
- byte_valid_i  in  1  byte_i valid
- byte_ready_o  out  1  block can accept a byte this cycle
- pm_addr_o  out  ADDR_W  PM address
- pm_data_o  out  WORD_SIZE  PM write data
- pm_we_o  out  1  PM write enable
- pm_data_i  in  WORD_SIZE  PM read data (registered address, 1-cycle read)
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  verify mismatch, sticky until next accepted start

Behaviour:
- Reset (async, rst_ni=0):
  - All outputs 0; state IDLE; internal counters cleared.
  - Reset asserted mid-operation abandons it with no further writes; pm_we_o drops immediately.
- Byte transfer occurs when byte_valid_i && byte_ready_o at a rising edge.
- FSM states: IDLE, FILL_LO, FILL_HI, WRITE, VERIFY, DONE.
- IDLE:
  - byte_ready_o=0, busy_o=0.
  - On start_i: latch base_i into addr, len_i into remaining, clear err_o.
  - If len_i=0 go to DONE, otherwise FILL_LO.
- FILL_LO: byte_ready_o=1; on transfer store byte into data[7:0], go to FILL_HI.
- FILL_HI: byte_ready_o=1; on transfer store byte into data[15:8], go to WRITE.
- WRITE:
  - pm_we_o=1 for exactly one cycle; pm_addr_o=addr, pm_data_o=assembled word; byte_ready_o=0.
  - Always go to VERIFY.
- VERIFY:
  - pm_we_o=0; pm_addr_o held. pm_data_i reflects the word just written (PM samples the address on the write edge).
  - If pm_data_i != pm_data_o: set err_o, go to DONE.
  - Else: addr <= addr+1 modulo 2^ADDR_W (wrap from all-ones to 0 with no error); remaining <= remaining-1.
  - If the new remaining is 0 go to DONE, else FILL_LO.
- DONE: done_o=1 for one cycle, busy_o=0, go to IDLE.
- busy_o=1 in FILL_LO, FILL_HI, WRITE and VERIFY.
- Throughput: 4 cycles per word minimum with back-to-back bytes. Start-to-first-write latency is 3 cycles with bytes already valid.
- start_i while not IDLE is ignored.
- abort_i:
  - In FILL_LO, FILL_HI, WRITE or VERIFY: go to IDLE next cycle with no done_o; any partial byte is discarded.
  - If abort_i coincides with WRITE, that single write still occurs (pm_we_o is already asserted that cycle); no further writes follow.
  - In DONE: ignored.
- Bytes offered while byte_ready_o=0 are not consumed.
- pm_data_o and pm_addr_o hold their last values outside WRITE/VERIFY.

Test Plan:
- Reset, then start base=0x0100 len=2, bytes 0x34,0x12,0x78,0x56 back-to-back -> pm_we_o pulses with (0x0100,0x1234) then (0x0101,0x5678), 4 cycles apart; done_o pulses once; err_o=0.
- start len=0 -> no pm_we_o; done_o one cycle after start; byte_ready_o stays 0.
- Model PM returns 0xFFFF on addr 0x0005; start base=0x0004 len=3 -> writes to 0x0004 and 0x0005 only; err_o=1 from the VERIFY cycle of 0x0005; done_o pulses; err_o clears on the next start.
- start base=0x1FFF len=2 -> writes land at 0x1FFF then 0x0000; no error.
- Stall byte_valid_i randomly; assert abort_i in FILL_HI, and separately start_i while busy -> no write after abort; state returns to IDLE; busy start ignored.
- Assert rst_ni=0 in the WRITE cycle -> pm_we_o goes 0 asynchronously; all outputs 0; no done_o.
